// File: rtl/serq_pkg.sv
// Shared types, defaults and width helpers for the serial queue controller.
package serq_pkg;

    typedef enum logic [1:0] {SHIFT, HOLD, PUSH} serq_state_t;

    localparam int SERQ_DATA_W  = 8;
    localparam int SERQ_DEPTH   = 8;
    localparam int SERQ_BIT_DIV = 10;

    // Bits needed to hold the values 0..max_val (never less than 1).
    function automatic int cnt_w(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits needed to address 'depth' entries (never less than 1).
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/serq_fifo.sv
// DATA_W x DEPTH synchronous FIFO with registered read port, occupancy count
// and registered full/empty flags. A pop makes room for a same-cycle push.
module serq_fifo
    import serq_pkg::*;
#(
    parameter int DATA_W = SERQ_DATA_W,
    parameter int DEPTH  = SERQ_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic [DATA_W-1:0]       wdata,
    input  logic                    pop,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rvalid,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = ptr_w(DEPTH);
    localparam int LW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push_fire, pop_fire;
    logic [LW-1:0]     count_nxt;

    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);

    always_comb begin
        count_nxt = count;
        if (push_fire && !pop_fire)
            count_nxt = count + LW'(1);
        else if (pop_fire && !push_fire)
            count_nxt = count - LW'(1);
    end

    always_ff @(posedge clk) begin
        if (push_fire)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_fire)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
                rdata  <= mem[rd_ptr];
            end
            rvalid <= pop_fire;
            count  <= count_nxt;
            full   <= (count_nxt == LW'(DEPTH));
            empty  <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/serial_queue_ctrl.sv
// Serial deserializer + enqueue FSM feeding a FIFO, all on clock1M with a bit-slot enable.
// Optional even-parity check per word when SERQ_PARITY_EN is defined.
module serial_queue_ctrl
    import serq_pkg::*;
#(
    parameter int DATA_W  = SERQ_DATA_W,
    parameter int DEPTH   = SERQ_DEPTH,
    parameter int BIT_DIV = SERQ_BIT_DIV
) (
    input  logic                    clock1M,
    input  logic                    reset,
    input  logic                    data_in,
    input  logic                    write_in,
    input  logic                    dequeue_in,
    output logic [DATA_W-1:0]       data_out,
    output logic                    data_valid,
    output logic [cnt_w(DEPTH)-1:0] len_out,
    output logic                    status_out,
    output logic                    full,
    output logic                    empty
`ifdef SERQ_PARITY_EN
    ,
    output logic                    parity_err
`endif
);
`ifdef SERQ_PARITY_EN
    localparam int NBITS = DATA_W + 1;
`else
    localparam int NBITS = DATA_W;
`endif
    localparam int TW = cnt_w(BIT_DIV - 1);
    localparam int CW = cnt_w(NBITS);

    serq_state_t       state, state_nxt;
    logic [TW-1:0]     tick_cnt;
    logic              bit_tick, shift_en, last_bit, pop_req, push;
    logic [DATA_W-1:0] sr;
    logic [CW-1:0]     bit_cnt;

    assign bit_tick   = (tick_cnt == TW'(BIT_DIV - 1));
    assign shift_en   = (state == SHIFT) && bit_tick && write_in;
    assign last_bit   = shift_en && (bit_cnt == CW'(NBITS - 1));
    assign pop_req    = dequeue_in && !empty;
    assign status_out = (state == SHIFT);

`ifdef SERQ_PARITY_EN
    logic par_bit, par_bad;
    assign par_bad    = ^{sr, par_bit};
    assign parity_err = (state == HOLD) && par_bad;
`endif

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset)
            tick_cnt <= '0;
        else if (bit_tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset)
            state <= SHIFT;
        else
            state <= state_nxt;
    end

    // The final bit moves straight to HOLD so the word lands two edges later.
    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        case (state)
            SHIFT: if (last_bit) state_nxt = HOLD;
            HOLD: begin
`ifdef SERQ_PARITY_EN
                if (par_bad)
                    state_nxt = SHIFT;
                else
`endif
                if (!full || pop_req)
                    state_nxt = PUSH;
            end
            PUSH: begin
                push      = 1'b1;
                state_nxt = SHIFT;
            end
            default: state_nxt = SHIFT;
        endcase
    end

    always_ff @(posedge clock1M or negedge reset) begin
        if (!reset) begin
            sr      <= '0;
            bit_cnt <= '0;
`ifdef SERQ_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (shift_en) begin
`ifdef SERQ_PARITY_EN
            if (bit_cnt == CW'(DATA_W))
                par_bit <= data_in;
            else
`endif
            sr <= {sr[DATA_W-2:0], data_in};
            bit_cnt <= bit_cnt + CW'(1);
        end else if (state != SHIFT && state_nxt == SHIFT) begin
            bit_cnt <= '0;
        end
    end

    serq_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk    (clock1M),
        .reset  (reset),
        .push   (push),
        .wdata  (sr),
        .pop    (dequeue_in),
        .rdata  (data_out),
        .rvalid (data_valid),
        .count  (len_out),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_serial_queue_ctrl.sv
// Directed bench for serial_queue_ctrl: table of single-word vectors plus
// hand-written fill/backpressure, simultaneous push/pop, empty-pop and reset sequences.
module tb_serial_queue_ctrl;
    localparam int DW      = 8;
    localparam int DEPTH   = 8;
    localparam int BIT_DIV = 10;
    localparam int LW      = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          data_in = 1'b0;
    logic          write_in = 1'b0;
    logic          dequeue_in = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [LW-1:0] len_out;
    logic          status_out, full, empty;

    int errors = 0;
    int checks = 0;
    int edge_n;

    typedef struct {
        logic [DW-1:0] word;
        int            gap_at;
        int            gap_len;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    serial_queue_ctrl #(.DATA_W(DW), .DEPTH(DEPTH), .BIT_DIV(BIT_DIV)) dut (
        .clock1M    (clk),
        .reset      (reset),
        .data_in    (data_in),
        .write_in   (write_in),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .len_out    (len_out),
        .status_out (status_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    // Edges since reset release; bit slots are sampled on edges that are multiples of BIT_DIV.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    initial begin
        #400000;
        $display("FAIL timeout: run did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic send_bit(input logic d, input logic w);
        @(negedge clk);
        while (edge_n % BIT_DIV != BIT_DIV - 1) @(negedge clk);
        data_in  = d;
        write_in = w;
        @(posedge clk);
        #1;
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int gap_at, input int gap_len);
        for (int i = 0; i < DW; i++) begin
            if (i == gap_at)
                for (int g = 0; g < gap_len; g++) send_bit(1'($urandom), 1'b0);
            send_bit(w[DW-1-i], 1'b1);
        end
    endtask

    task automatic settle3;
        repeat (3) @(negedge clk);
    endtask

    task automatic pop_check(input logic [DW-1:0] exp, input int exp_len);
        @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("pop data_out", data_out, exp);
        check("pop data_valid", data_valid, 1);
        check("pop len_out", len_out, exp_len);
    endtask

    initial begin
        vecs[0] = '{8'hA5, -1, 0, 8'hA5};
        vecs[1] = '{8'h3C,  4, 3, 8'h3C};
        vecs[2] = '{8'h00, -1, 0, 8'h00};
        vecs[3] = '{8'hFF,  1, 2, 8'hFF};
        vecs[4] = '{8'h80, -1, 0, 8'h80};
        vecs[5] = '{8'h01,  7, 1, 8'h01};

        // Reset with random inputs
        repeat (5) begin
            @(negedge clk);
            data_in    = 1'($urandom);
            write_in   = 1'($urandom);
            dequeue_in = 1'($urandom);
        end
        check("rst len_out", len_out, 0);
        check("rst empty", empty, 1);
        check("rst full", full, 0);
        check("rst status_out", status_out, 1);
        check("rst data_out", data_out, 0);
        check("rst data_valid", data_valid, 0);
        data_in = 1'b0; write_in = 1'b0; dequeue_in = 1'b0;
        reset = 1'b1;

        // Single-word vectors with optional write_in gaps
        for (int v = 0; v < 6; v++) begin
            send_word(vecs[v].word, vecs[v].gap_at, vecs[v].gap_len);
            @(negedge clk);
            check("vec hold status", status_out, 0);
            check("vec len +1", len_out, 0);
            @(negedge clk);
            check("vec len +2 edge pre", len_out, 0);
            @(negedge clk);
            check("vec len latency", len_out, 1);
            check("vec status back", status_out, 1);
            check("vec empty", empty, 0);
            pop_check(vecs[v].exp, 0);
            check("vec empty after pop", empty, 1);
            @(negedge clk);
            check("vec valid pulse", data_valid, 0);
        end

        // Fill to DEPTH, then a ninth word waits in HOLD
        for (int k = 1; k <= 8; k++) send_word(8'(k), -1, 0);
        settle3();
        check("fill full", full, 1);
        check("fill len", len_out, 8);
        send_word(8'h09, -1, 0);
        settle3();
        check("bp status", status_out, 0);
        check("bp len", len_out, 8);
        send_word(8'hFF, -1, 0);
        check("bp ignored status", status_out, 0);
        check("bp ignored len", len_out, 8);
        pop_check(8'h01, 7);
        @(negedge clk);
        check("bp refill len", len_out, 8);
        check("bp refill full", full, 1);
        check("bp status after push", status_out, 1);
        for (int k = 2; k <= 9; k++) pop_check(8'(k), 9 - k);
        check("drain empty", empty, 1);

        // Pop in the same cycle as PUSH
        send_word(8'h11, -1, 0);
        send_word(8'h22, -1, 0);
        send_word(8'h33, -1, 0);
        settle3();
        check("sim pre len", len_out, 3);
        send_word(8'h44, -1, 0);
        @(negedge clk);
        @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("sim len", len_out, 3);
        check("sim data_out", data_out, 8'h11);
        check("sim data_valid", data_valid, 1);
        pop_check(8'h22, 2);
        pop_check(8'h33, 1);
        pop_check(8'h44, 0);

        // Pop while empty
        @(negedge clk);
        dequeue_in = 1'b1;
        @(negedge clk);
        dequeue_in = 1'b0;
        check("empty pop valid", data_valid, 0);
        check("empty pop data", data_out, 8'h44);
        check("empty pop len", len_out, 0);
        check("empty pop empty", empty, 1);

        // Reset mid-word with a stored word
        send_word(8'h77, -1, 0);
        settle3();
        check("mid pre len", len_out, 1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid rst len", len_out, 0);
        check("mid rst empty", empty, 1);
        check("mid rst data_out", data_out, 0);
        check("mid rst status", status_out, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        send_word(8'h5A, -1, 0);
        settle3();
        check("mid post len", len_out, 1);
        pop_check(8'h5A, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
